// File: rtl/id_pipe_stage_if.sv
// Handshake and payload bundle between the IF stage, the ID/EX register and write-back.
// The master side drives instructions and write-backs; the slave side is the decode stage.
interface id_pipe_stage_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_npc;
    logic [31:0]     in_ir;
    logic            imm_sign;
    logic            wb_en;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_npc;
    logic [31:0]     out_ir;
    logic [XLEN-1:0] out_a;
    logic [XLEN-1:0] out_b;
    logic [XLEN-1:0] out_imm;

    modport master (
        output in_valid, in_npc, in_ir, imm_sign, wb_en, wb_addr, wb_data, flush, out_ready,
        input  in_ready, out_valid, out_npc, out_ir, out_a, out_b, out_imm
    );

    modport slave (
        input  in_valid, in_npc, in_ir, imm_sign, wb_en, wb_addr, wb_data, flush, out_ready,
        output in_ready, out_valid, out_npc, out_ir, out_a, out_b, out_imm
    );
endinterface

// File: rtl/id_pipe_stage.sv
// Instruction-decode stage: register file, operand fetch with write-back bypass,
// immediate extension and a single-entry ID/EX register with valid/ready flow control.
module id_pipe_stage #(
    parameter int XLEN      = 32,
    parameter int REG_COUNT = 32,
    parameter int IMM_W     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    id_pipe_stage_if.slave  io_bus
);
    localparam int AW = $clog2(REG_COUNT);
    localparam logic [XLEN-1:0] EXT_MASK = ~((XLEN'(1) << IMM_W) - XLEN'(1));

    logic [XLEN-1:0] r_regs [REG_COUNT];
    logic            r_outValid;
    logic [XLEN-1:0] r_outNpc;
    logic [31:0]     r_outIr;
    logic [XLEN-1:0] r_outA;
    logic [XLEN-1:0] r_outB;
    logic [XLEN-1:0] r_outImm;

    logic [AW-1:0]   w_rs;
    logic [AW-1:0]   w_rt;
    logic [AW-1:0]   w_heldRs;
    logic [AW-1:0]   w_heldRt;
    logic            w_wbHit;
    logic            w_inReady;
    logic            w_load;
    logic [XLEN-1:0] w_opA;
    logic [XLEN-1:0] w_opB;
    logic [XLEN-1:0] w_imm;

    assign w_rs     = io_bus.in_ir[21 +: AW];
    assign w_rt     = io_bus.in_ir[16 +: AW];
    assign w_heldRs = r_outIr[21 +: AW];
    assign w_heldRt = r_outIr[16 +: AW];
    assign w_wbHit  = io_bus.wb_en && (io_bus.wb_addr != '0);

    // Reset is folded in so the stage never advertises readiness while held in reset.
    assign w_inReady = rst_n && !io_bus.flush && (!r_outValid || io_bus.out_ready);
    assign w_load    = io_bus.in_valid && w_inReady;

    // Write-back wins over the stored value so an instruction sees a same-cycle write.
    always_comb begin
        w_opA = r_regs[w_rs];
        w_opB = r_regs[w_rt];
        if (w_wbHit && (io_bus.wb_addr == w_rs)) w_opA = io_bus.wb_data;
        if (w_wbHit && (io_bus.wb_addr == w_rt)) w_opB = io_bus.wb_data;
    end

    always_comb begin
        w_imm = XLEN'(io_bus.in_ir[IMM_W-1:0]);
        if (io_bus.imm_sign && io_bus.in_ir[IMM_W-1]) w_imm = w_imm | EXT_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= '0;
        end else if (w_wbHit) begin
            r_regs[io_bus.wb_addr] <= io_bus.wb_data;
        end
    end

    // Flush beats everything; a held instruction keeps tracking write-backs to its sources.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outValid <= 1'b0;
            r_outNpc   <= '0;
            r_outIr    <= '0;
            r_outA     <= '0;
            r_outB     <= '0;
            r_outImm   <= '0;
        end else if (io_bus.flush) begin
            r_outValid <= 1'b0;
        end else if (w_load) begin
            r_outValid <= 1'b1;
            r_outNpc   <= io_bus.in_npc;
            r_outIr    <= io_bus.in_ir;
            r_outA     <= w_opA;
            r_outB     <= w_opB;
            r_outImm   <= w_imm;
        end else if (r_outValid && io_bus.out_ready) begin
            r_outValid <= 1'b0;
        end else if (r_outValid) begin
            if (w_wbHit && (io_bus.wb_addr == w_heldRs)) r_outA <= io_bus.wb_data;
            if (w_wbHit && (io_bus.wb_addr == w_heldRt)) r_outB <= io_bus.wb_data;
        end
    end

    assign io_bus.in_ready  = w_inReady;
    assign io_bus.out_valid = r_outValid;
    assign io_bus.out_npc   = r_outNpc;
    assign io_bus.out_ir    = r_outIr;
    assign io_bus.out_a     = r_outA;
    assign io_bus.out_b     = r_outB;
    assign io_bus.out_imm   = r_outImm;
endmodule

// File: tb/tb_id_pipe_stage.sv
// Self-checking bench for id_pipe_stage: directed scenarios followed by random traffic
// compared against a behavioural model of the decode stage.
module tb_id_pipe_stage;
    localparam int XLEN      = 32;
    localparam int REG_COUNT = 32;
    localparam int IMM_W     = 16;
    localparam int AW        = $clog2(REG_COUNT);

    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;

    longint unsigned refRegs [REG_COUNT];
    bit              refValid;
    longint unsigned refNpc, refIr, refA, refB, refImm;

    id_pipe_stage_if #(.XLEN(XLEN), .AW(AW)) bus ();

    id_pipe_stage #(.XLEN(XLEN), .REG_COUNT(REG_COUNT), .IMM_W(IMM_W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input bit valid, input logic [31:0] npc, input logic [31:0] ir,
                                 input bit sign, input bit wbEn, input int wbAddr,
                                 input logic [31:0] wbData, input bit flush, input bit outReady);
        bus.in_valid  = valid;
        bus.in_npc    = npc;
        bus.in_ir     = ir;
        bus.imm_sign  = sign;
        bus.wb_en     = wbEn;
        bus.wb_addr   = AW'(wbAddr);
        bus.wb_data   = wbData;
        bus.flush     = flush;
        bus.out_ready = outReady;
    endtask

    function automatic logic [31:0] makeIr(input int rs, input int rt, input int imm);
        return (32'(rs) << 21) | (32'(rt) << 16) | 32'(imm & 16'hFFFF);
    endfunction

    task automatic resetModel();
        for (int i = 0; i < REG_COUNT; i++) refRegs[i] = 0;
        refValid = 0;
        refNpc = 0; refIr = 0; refA = 0; refB = 0; refImm = 0;
    endtask

    function automatic longint unsigned readOperand(input int idx);
        if (idx == 0) return 0;
        if (bus.wb_en && int'(bus.wb_addr) == idx) return longint'(bus.wb_data);
        return refRegs[idx];
    endfunction

    function automatic longint unsigned immModel();
        longint unsigned raw;
        raw = longint'(bus.in_ir) % (longint'(1) << IMM_W);
        if (bus.imm_sign && raw >= (longint'(1) << (IMM_W - 1)))
            raw = raw + (longint'(1) << XLEN) - (longint'(1) << IMM_W);
        return raw;
    endfunction

    function automatic bit expectedReady();
        return rst_n && !bus.flush && (!refValid || bus.out_ready);
    endfunction

    // Advance the model by one rising edge using the inputs currently driven.
    task automatic updateModel();
        int  rs, rt, heldRs, heldRt, wa;
        bit  accept;
        rs     = int'(bus.in_ir >> 21) % REG_COUNT;
        rt     = int'(bus.in_ir >> 16) % REG_COUNT;
        heldRs = int'(refIr >> 21) % REG_COUNT;
        heldRt = int'(refIr >> 16) % REG_COUNT;
        wa     = int'(bus.wb_addr);
        accept = bus.in_valid && expectedReady();
        if (bus.flush) begin
            refValid = 0;
        end else if (accept) begin
            refValid = 1;
            refNpc   = bus.in_npc;
            refIr    = bus.in_ir;
            refA     = readOperand(rs);
            refB     = readOperand(rt);
            refImm   = immModel();
        end else if (refValid && bus.out_ready) begin
            refValid = 0;
        end else if (refValid) begin
            if (bus.wb_en && wa != 0 && wa == heldRs) refA = bus.wb_data;
            if (bus.wb_en && wa != 0 && wa == heldRt) refB = bus.wb_data;
        end
        if (bus.wb_en && wa != 0) refRegs[wa] = bus.wb_data;
    endtask

    task automatic checkModel(input string pfx);
        checkOutput({pfx, ".valid"}, 64'(bus.out_valid), 64'(refValid));
        checkOutput({pfx, ".npc"},   64'(bus.out_npc),   refNpc);
        checkOutput({pfx, ".ir"},    64'(bus.out_ir),    refIr);
        checkOutput({pfx, ".a"},     64'(bus.out_a),     refA);
        checkOutput({pfx, ".b"},     64'(bus.out_b),     refB);
        checkOutput({pfx, ".imm"},   64'(bus.out_imm),   refImm);
    endtask

    task automatic stepCycle(input string pfx);
        @(negedge clk);
        checkOutput({pfx, ".in_ready"}, 64'(bus.in_ready), 64'(expectedReady()));
        @(posedge clk);
        updateModel();
        #1;
        checkModel(pfx);
    endtask

    initial begin
        logic [31:0] heldIr;
        logic [31:0] ir;
        int          wbAddr;
        checkCount = 0;
        errorCount = 0;
        resetModel();

        rst_n = 1'b0;
        applyStimulus(1, 32'h40, makeIr(1, 2, 3), 0, 0, 0, 0, 0, 1);
        #2;
        checkOutput("rst.out_valid", 64'(bus.out_valid), 0);
        checkOutput("rst.in_ready",  64'(bus.in_ready),  0);
        checkOutput("rst.out_a",     64'(bus.out_a),     0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        stepCycle("idle");

        // Write r3, then load with sign-extended immediate.
        applyStimulus(0, 0, 0, 0, 1, 3, 32'h1234_5678, 0, 1);
        stepCycle("r34wb");
        applyStimulus(1, 32'h100, makeIr(3, 0, 16'h8000), 1, 0, 0, 0, 0, 1);
        stepCycle("r34ld");
        checkOutput("r34.valid", 64'(bus.out_valid), 1);
        checkOutput("r34.a",     64'(bus.out_a),     64'h1234_5678);
        checkOutput("r34.b",     64'(bus.out_b),     0);
        checkOutput("r34.imm",   64'(bus.out_imm),   64'hFFFF_8000);

        // Same-cycle bypass with zero-extended immediate.
        applyStimulus(1, 32'h104, makeIr(5, 0, 16'h8000), 0, 1, 5, 32'hA5A5_A5A5, 0, 1);
        stepCycle("r35");
        checkOutput("r35.a",   64'(bus.out_a),   64'hA5A5_A5A5);
        checkOutput("r35.imm", 64'(bus.out_imm), 64'h0000_8000);

        // Hold for three cycles with a write-back to the held rt in the middle one.
        heldIr = makeIr(1, 7, 16'h0042);
        applyStimulus(1, 32'h108, heldIr, 0, 0, 0, 0, 0, 1);
        stepCycle("r36ld");
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1, 32'h200 + 32'(c), makeIr(2, 3, c), 0, (c == 1), 7, 32'h0000_00FF, 0, 0);
            stepCycle("r36hold");
            checkOutput("r36.in_ready", 64'(bus.in_ready), 0);
        end
        checkOutput("r36.b",     64'(bus.out_b),     64'hFF);
        checkOutput("r36.ir",    64'(bus.out_ir),    64'(heldIr));
        checkOutput("r36.npc",   64'(bus.out_npc),   64'h108);
        checkOutput("r36.valid", 64'(bus.out_valid), 1);

        // Register 0 ignores writes and bypass.
        applyStimulus(0, 0, 0, 0, 1, 0, 32'hDEAD_BEEF, 0, 1);
        stepCycle("r37wr");
        applyStimulus(1, 32'h300, makeIr(0, 0, 1), 0, 1, 0, 32'hDEAD_BEEF, 0, 1);
        stepCycle("r37rd");
        checkOutput("r37.a", 64'(bus.out_a), 0);

        // Flush during hold with an incoming instruction, then a 4-deep stream.
        heldIr = makeIr(3, 5, 9);
        applyStimulus(1, 32'h400, heldIr, 0, 0, 0, 0, 0, 1);
        stepCycle("r38ld");
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
        stepCycle("r38hold");
        applyStimulus(1, 32'h500, makeIr(4, 4, 4), 0, 0, 0, 0, 1, 0);
        checkOutput("r38.flush_ready", 64'(bus.in_ready), 0);
        stepCycle("r38fl");
        checkOutput("r38.valid", 64'(bus.out_valid), 0);
        checkOutput("r38.ir",    64'(bus.out_ir),    64'(heldIr));
        checkOutput("r38.npc",   64'(bus.out_npc),   64'h400);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 32'h600 + 32'(4 * k), makeIr(k + 1, k + 2, k), 0, 0, 0, 0, 0, 1);
            stepCycle("r38stream");
            checkOutput("r38.stream_valid", 64'(bus.out_valid), 1);
            checkOutput("r38.stream_npc",   64'(bus.out_npc),   64'(32'h600 + 32'(4 * k)));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        stepCycle("r38drain");
        checkOutput("r38.drained", 64'(bus.out_valid), 0);

        // Asynchronous reset between edges while holding, with a write pending.
        applyStimulus(1, 32'h700, makeIr(3, 5, 1), 0, 0, 0, 0, 0, 1);
        stepCycle("r39ld");
        checkOutput("r39.a_pre", 64'(bus.out_a), 64'h1234_5678);
        applyStimulus(0, 0, 0, 0, 1, 9, 32'h55, 0, 0);
        stepCycle("r39hold");
        applyStimulus(0, 0, 0, 0, 1, 10, 32'h77, 0, 0);
        #3;
        rst_n = 1'b0;
        resetModel();
        #1;
        checkOutput("r39.valid", 64'(bus.out_valid), 0);
        checkOutput("r39.a",     64'(bus.out_a),     0);
        checkOutput("r39.ready", 64'(bus.in_ready),  0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 32'h800, makeIr(3, 9, 0), 0, 0, 0, 0, 0, 1);
        stepCycle("r39rd");
        checkOutput("r39.a_post", 64'(bus.out_a), 0);
        checkOutput("r39.b_post", 64'(bus.out_b), 0);
        applyStimulus(1, 32'h804, makeIr(10, 0, 0), 0, 0, 0, 0, 0, 1);
        stepCycle("r39rd2");
        checkOutput("r39.a_post2", 64'(bus.out_a), 0);

        // Random traffic; write-back addresses are biased toward the live source fields.
        for (int n = 0; n < 600; n++) begin
            ir = $urandom;
            case ($urandom_range(0, 3))
                0:       wbAddr = int'(ir >> 21) % REG_COUNT;
                1:       wbAddr = int'(ir >> 16) % REG_COUNT;
                2:       wbAddr = int'(refIr >> 21) % REG_COUNT;
                default: wbAddr = $urandom_range(0, REG_COUNT - 1);
            endcase
            applyStimulus($urandom_range(0, 3) != 0, $urandom, ir, $urandom_range(0, 1),
                          $urandom_range(0, 1), wbAddr, $urandom,
                          $urandom_range(0, 9) == 0, $urandom_range(0, 2) != 0);
            stepCycle("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end
endmodule
